md_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers, in the EX stage.

---
 rtl/md_unit_if.sv | 12 +
 rtl/md_unit.sv | 65 ++++++
 tb/tb_md_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: operand/op bus into the multiply/divide unit and its busy/HI/LO results.
interface md_unit_if;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, mdOp, rsData, rtData, input busy, hi, lo);
    modport slave  (input start, mdOp, rsData, rtData, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: fixed-latency multiply/divide unit with HI/LO registers for the EX stage.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset_n,
    md_unit_if.slave  md
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_q, lo_q, pend_hi, pend_lo;
    logic          is_mul, is_div, an, bn;
    logic [31:0]   a, b, q, r, res_hi, res_lo;
    logic [63:0]   prod;
    // Signed divide works on magnitudes, so MIN_INT / -1 naturally yields MIN_INT rem 0.
    always_comb begin
        is_mul = md.mdOp == 3'd1 || md.mdOp == 3'd2;
        is_div = md.mdOp == 3'd3 || md.mdOp == 3'd4;
        an     = md.mdOp == 3'd3 && md.rsData[31];
        bn     = md.mdOp == 3'd3 && md.rtData[31];
        a      = an ? -md.rsData : md.rsData;
        b      = bn ? -md.rtData : md.rtData;
        q      = a / (b == 32'd0 ? 32'd1 : b);
        r      = a % (b == 32'd0 ? 32'd1 : b);
        prod   = md.mdOp == 3'd1 ? {{32{md.rsData[31]}}, md.rsData} * {{32{md.rtData[31]}}, md.rtData}
                                 : {32'd0, md.rsData} * {32'd0, md.rtData};
        res_hi = is_mul ? prod[63:32] : b == 32'd0 ? hi_q : an ? -r : r;
        res_lo = is_mul ? prod[31:0]  : b == 32'd0 ? lo_q : (an ^ bn) ? -q : q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (state == IDLE) begin
            if (md.start && (is_mul || is_div)) begin
                state   <= BUSY;
                cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end else if (md.start && md.mdOp == 3'd5) begin
                hi_q <= md.rsData;
            end else if (md.start && md.mdOp == 3'd6) begin
                lo_q <= md.rsData;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state <= IDLE;
                hi_q  <= pend_hi;
                lo_q  <= pend_lo;
            end
        end
    end
    assign md.busy = state == BUSY;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench; stimulus queues expected HI/LO/latency, a monitor checks on busy fall.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    md_unit_if bus ();
    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset_n(reset_n), .md(bus.slave));
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles and scores each completed (or aborted) operation.
    initial begin
        logic prev_busy;
        int   bcnt;
        exp_t e;
        prev_busy = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                bcnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: busy fell with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_hi"}, bus.hi, e.hi);
                    check({e.name, "_lo"}, bus.lo, e.lo);
                    if (e.cycles != 0) check({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.cycles));
                end
                bcnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    // Inputs are driven 1ns after an edge; returns 1ns after the edge that samples them.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.mdOp   = op;
        bus.rsData = rs;
        bus.rtData = rt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mdOp  = 3'd0;
    endtask

    task automatic push_exp(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        exp_t e;
        e.name = name;
        e.hi = hi;
        e.lo = lo;
        e.cycles = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mdOp = 3'd0;
        bus.rsData = '0;
        bus.rtData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // MULT / MULTU
        push_exp("mult_3x-2", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(3'd1, 32'd3, 32'hFFFFFFFE);
        wait_idle();
        push_exp("multu_ffffffffx2", 32'h00000001, 32'hFFFFFFFE, 5);
        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle();
        // DIV / DIVU with mixed signs
        push_exp("div_-7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        push_exp("div_7/-2", 32'h00000001, 32'hFFFFFFFD, 10);
        issue(3'd3, 32'd7, 32'hFFFFFFFE);
        wait_idle();
        push_exp("divu_fffffff9/2", 32'h00000001, 32'h7FFFFFFC, 10);
        issue(3'd4, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        // Divide by zero keeps HI/LO
        issue(3'd5, 32'h1234, 32'd0);
        check("mthi_hi", bus.hi, 32'h1234);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        issue(3'd6, 32'h1234, 32'd0);
        check("mtlo_lo", bus.lo, 32'h1234);
        push_exp("divu_7/0", 32'h1234, 32'h1234, 10);
        issue(3'd4, 32'd7, 32'd0);
        wait_idle();
        // MTHI while busy is ignored
        push_exp("mult_5x6", 32'd0, 32'd30, 5);
        issue(3'd1, 32'd5, 32'd6);
        issue(3'd5, 32'hAAAA0000, 32'd0);
        check("mthi_while_busy_hi", bus.hi, 32'h1234);
        check("busy_during_mult", 32'(bus.busy), 32'd1);
        wait_idle();
        // No-op codes ignored, MTLO while idle
        issue(3'd7, 32'hDEADBEEF, 32'd3);
        issue(3'd0, 32'hDEADBEEF, 32'd3);
        check("noop_hi", bus.hi, 32'd0);
        check("noop_lo", bus.lo, 32'd30);
        check("noop_busy", 32'(bus.busy), 32'd0);
        issue(3'd6, 32'h55, 32'd0);
        check("mtlo_55_lo", bus.lo, 32'h55);
        check("mtlo_55_busy", 32'(bus.busy), 32'd0);
        // Overflow divide, then MULT issued the cycle busy falls
        push_exp("div_minint/-1", 32'd0, 32'h80000000, 10);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        push_exp("mult_backtoback", 32'hFFFFFFFF, 32'h80000000, 5);
        issue(3'd1, 32'hFFFFFFFE, 32'h40000000);
        check("backtoback_busy", 32'(bus.busy), 32'd1);
        wait_idle();
        // Asynchronous reset mid-divide
        push_exp("div_aborted", 32'd0, 32'd0, 0);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        check("async_reset_hi", bus.hi, 32'd0);
        check("async_reset_lo", bus.lo, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_reset_busy", 32'(bus.busy), 32'd0);
        check("post_reset_hi", bus.hi, 32'd0);
        check("post_reset_lo", bus.lo, 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
